pipelined_cla_addsub: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups, one group per pipeline stage, with the group carry registered between stages. It is the general-width arithmetic unit for the datapath. It replaces fixed 4-bit combinational adders wherever wider operands, subtraction, carry-in or a registered result with flow control is needed. Full throughput: one operation per cycle unless the consumer stalls.

---
 rtl/pipelined_cla_addsub.sv | 119 +++++++++++
 tb/tb_pipelined_cla_addsub.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one 4-bit lookahead group per stage,
// group carry registered between stages, valid/ready flow control with a global stall.
module pipelined_cla_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  input  logic             CIN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  localparam int GROUPS = WIDTH / 4;

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("pipelined_cla_addsub: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  // 4-bit lookahead group: returns {group carry-out, sum[3:0]}
  function automatic logic [4:0] cla_group(input logic [3:0] a, input logic [3:0] b,
                                           input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       gg;
    logic       pg;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pg   = &p;
    return {gg | (pg & ci), p ^ c};
  endfunction

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             stall;

  logic [WIDTH-1:0] a_src [GROUPS];
  logic [WIDTH-1:0] b_src [GROUPS];
  logic [WIDTH-1:0] s_src [GROUPS];
  logic             c_src [GROUPS];
  logic [4:0]       grp   [GROUPS];
  logic [WIDTH-1:0] s_nxt [GROUPS];

  logic [WIDTH-1:0] a_q   [GROUPS];
  logic [WIDTH-1:0] b_q   [GROUPS];
  logic [WIDTH-1:0] s_q   [GROUPS];
  logic             c_q   [GROUPS];
  logic [GROUPS-1:0] v_q;

  assign b_eff    = SUB ? ~B : B;
  assign c0       = SUB ? ~CIN : CIN;
  assign stall    = v_q[GROUPS-1] & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    a_src[0] = A;
    b_src[0] = b_eff;
    s_src[0] = '0;
    c_src[0] = c0;
    for (int k = 1; k < GROUPS; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
    end
    for (int k = 0; k < GROUPS; k++) begin
      grp[k]             = cla_group(a_src[k][4*k +: 4], b_src[k][4*k +: 4], c_src[k]);
      s_nxt[k]           = s_src[k];
      s_nxt[k][4*k +: 4] = grp[k][3:0];
    end
  end

  // Operands travel with the partial sum so the last stage still has the sign bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < GROUPS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      v_q[0] <= in_valid;
      for (int k = 1; k < GROUPS; k++) begin
        v_q[k] <= v_q[k-1];
      end
      for (int k = 0; k < GROUPS; k++) begin
        a_q[k] <= a_src[k];
        b_q[k] <= b_src[k];
        s_q[k] <= s_nxt[k];
        c_q[k] <= grp[k][4];
      end
    end
  end

  assign out_valid = v_q[GROUPS-1];
  assign SUM       = s_q[GROUPS-1];
  assign COUT      = c_q[GROUPS-1];
  // carry into the MSB is a^b^s at that bit; overflow when it differs from carry-out
  assign OVF       = a_q[GROUPS-1][WIDTH-1] ^ b_q[GROUPS-1][WIDTH-1]
                   ^ s_q[GROUPS-1][WIDTH-1] ^ c_q[GROUPS-1];

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub: WIDTH=16 and WIDTH=4 instances
// compared against an integer-arithmetic reference model.
module tb_pipelined_cla_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        iv16, ir16, ov16, or16, sub16, cin16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic        iv4, ir4, ov4, or4, sub4, cin4, cout4, ovf4;
  logic [3:0]  a4, b4, sum4;

  pipelined_cla_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
    .SUB(sub16), .CIN(cin16), .out_valid(ov16), .out_ready(or16), .SUM(sum16),
    .COUT(cout16), .OVF(ovf16));

  pipelined_cla_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
    .SUB(sub4), .CIN(cin4), .out_valid(ov4), .out_ready(or4), .SUM(sum4),
    .COUT(cout4), .OVF(ovf4));

  typedef struct {
    logic [17:0] res;
    int          t;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;
  int step_no = 0;

  logic        o_valid, o_ready, o_cout, o_ovf;
  logic [15:0] o_sum;

  // Reference: {ovf, cout, sum} from plain signed/unsigned integer arithmetic.
  function automatic logic [17:0] golden(input int w, input longint a, input longint b,
                                         input bit sub, input bit cin);
    longint m, sa, sb, ur, sr, msk;
    bit co, ov;
    m  = longint'(1) << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (!sub) begin
      ur = a + b + longint'(cin);
      co = (ur >= m);
      sr = sa + sb + longint'(cin);
    end else begin
      ur = a - b - longint'(cin);
      co = (a >= b + longint'(cin));
      sr = sa - sb - longint'(cin);
    end
    ov  = (sr < -(m / 2)) || (sr >= m / 2);
    msk = ur & (m - 1);
    return {ov, co, msk[15:0]};
  endfunction

  task automatic step16(input bit iv, input bit ordy, input logic [15:0] a,
                        input logic [15:0] b, input bit sub, input bit cin, input bit rst);
    @(negedge clk);
    reset = rst; iv16 = iv; or16 = ordy; a16 = a; b16 = b; sub16 = sub; cin16 = cin;
    #1;
    o_valid = ov16; o_ready = ir16; o_sum = sum16; o_cout = cout16; o_ovf = ovf16;
    step_no++;
  endtask

  task automatic step4(input bit iv, input logic [3:0] a, input logic [3:0] b,
                       input bit sub, input bit cin);
    @(negedge clk);
    reset = 1'b0; iv4 = iv; or4 = 1'b1; a4 = a; b4 = b; sub4 = sub; cin4 = cin;
    #1;
    o_valid = ov4; o_ready = ir4; o_sum = {12'h000, sum4}; o_cout = cout4; o_ovf = ovf4;
    step_no++;
  endtask

  task automatic test_reset();
    step16(0, 1, 16'h0, 16'h0, 0, 0, 1);
    step16(0, 1, 16'h0, 16'h0, 0, 0, 1);
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", o_valid); end
    n_cmp++; if (o_sum !== 16'h0) begin n_bad++; $display("FAIL reset_sum: got %h expected 0000", o_sum); end
    n_cmp++; if (o_cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout: got %b expected 0", o_cout); end
    n_cmp++; if (o_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", o_ovf); end
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", o_ready); end
    n_cmp++; if ({ov4, cout4, ovf4, sum4} !== 7'h0) begin n_bad++; $display("FAIL reset_w4: got %h expected 00", {ov4, cout4, ovf4, sum4}); end
  endtask

  task automatic test_directed();
    logic [15:0] ta [5] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0010};
    logic [15:0] tb [5] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0001};
    bit          ts [5] = '{0, 0, 1, 1, 1};
    bit          tc [5] = '{0, 0, 0, 0, 1};
    logic [17:0] te [5] = '{{2'b01, 16'h0000}, {2'b10, 16'h8000}, {2'b00, 16'hFFFE},
                            {2'b11, 16'h7FFF}, {2'b01, 16'h000E}};
    int lat;
    for (int i = 0; i < 5; i++) begin
      step16(1, 1, ta[i], tb[i], ts[i], tc[i], 0);
      lat = -1;
      for (int n = 1; n <= 10; n++) begin
        step16(0, 1, 16'h0, 16'h0, 0, 0, 0);
        if (o_valid) begin lat = n; break; end
      end
      n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL directed_latency[%0d]: got %0d expected 4", i, lat); end
      n_cmp++; if ({o_ovf, o_cout, o_sum} !== te[i]) begin
        n_bad++; $display("FAIL directed_result[%0d]: got ovf,cout,sum=%h expected %h", i, {o_ovf, o_cout, o_sum}, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    int got = 0;
    logic [15:0] a, b;
    bit sub, cin, iv;
    for (int n = 0; n < 40; n++) begin
      iv = (n < 20); a = 16'($urandom); b = 16'($urandom);
      sub = 1'($urandom); cin = 1'($urandom);
      step16(iv, 1, a, b, sub, cin, 0);
      n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got %b expected 1", o_ready); end
      if (o_valid) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL b2b_spurious: got out_valid=1 expected 0");
        end else begin
          e = q.pop_front(); got++;
          if ({o_ovf, o_cout, o_sum} !== e.res) begin
            n_bad++; $display("FAIL b2b_result: got %h expected %h", {o_ovf, o_cout, o_sum}, e.res);
          end
          n_cmp++; if (step_no - e.t != 4) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 4", step_no - e.t); end
        end
      end
      if (iv && o_ready) q.push_back('{golden(16, a, b, sub, cin), step_no});
    end
    n_cmp++; if (got != 20) begin n_bad++; $display("FAIL b2b_count: got %0d expected 20", got); end
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    exp_t e;
    logic [15:0] ra [30];
    logic [15:0] rb [30];
    bit rs [30];
    bit rc [30];
    int issued = 0;
    int got = 0;
    bit ordy, stalled_prev;
    logic [17:0] prev_out;
    for (int i = 0; i < 30; i++) begin
      ra[i] = 16'($urandom); rb[i] = 16'($urandom); rs[i] = 1'($urandom); rc[i] = 1'($urandom);
    end
    stalled_prev = 0; prev_out = '0;
    for (int n = 0; n < 80 && got < 30; n++) begin
      ordy = !(n >= 10 && n < 13);
      if (issued < 30) step16(1, ordy, ra[issued], rb[issued], rs[issued], rc[issued], 0);
      else             step16(0, ordy, 16'h0, 16'h0, 0, 0, 0);
      if (!ordy) begin
        n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_in_stall: got %b expected 1", o_valid); end
        n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_stall: got %b expected 0", o_ready); end
      end else begin
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL bp_in_ready: got %b expected 1", o_ready); end
      end
      if (stalled_prev) begin
        n_cmp++; if ({o_ovf, o_cout, o_sum} !== prev_out) begin
          n_bad++; $display("FAIL bp_hold: got %h expected %h", {o_ovf, o_cout, o_sum}, prev_out);
        end
      end
      if (o_valid && ordy) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL bp_spurious: got out_valid=1 expected 0");
        end else begin
          e = q.pop_front(); got++;
          if ({o_ovf, o_cout, o_sum} !== e.res) begin
            n_bad++; $display("FAIL bp_result: got %h expected %h", {o_ovf, o_cout, o_sum}, e.res);
          end
        end
      end
      if (issued < 30 && o_ready) begin
        q.push_back('{golden(16, ra[issued], rb[issued], rs[issued], rc[issued]), step_no});
        issued++;
      end
      stalled_prev = o_valid && !ordy;
      prev_out = {o_ovf, o_cout, o_sum};
    end
    n_cmp++; if (got != 30) begin n_bad++; $display("FAIL bp_count: got %0d expected 30", got); end
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL bp_leftover: got %0d expected 0", q.size()); end
  endtask

  task automatic test_reset_midstream();
    exp_t q[$];
    exp_t e;
    int got = 0;
    bit seen = 0;
    logic [15:0] a, b;
    bit sub, cin;
    for (int i = 0; i < 3; i++) step16(1, 1, 16'($urandom), 16'($urandom), 1'($urandom), 0, 0);
    step16(0, 1, 16'h0, 16'h0, 0, 0, 1);
    step16(0, 1, 16'h0, 16'h0, 0, 0, 0);
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b expected 0", o_valid); end
    n_cmp++; if ({o_ovf, o_cout, o_sum} !== 18'h0) begin
      n_bad++; $display("FAIL rst_mid_outputs: got %h expected 0", {o_ovf, o_cout, o_sum});
    end
    for (int n = 0; n < 6; n++) begin
      step16(0, 1, 16'h0, 16'h0, 0, 0, 0);
      if (o_valid) seen = 1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL rst_mid_flushed: got out_valid=1 expected 0"); end
    for (int n = 0; n < 12; n++) begin
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      step16(n < 5, 1, a, b, sub, cin, 0);
      if (o_valid) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL rst_post_spurious: got out_valid=1 expected 0");
        end else begin
          e = q.pop_front(); got++;
          if ({o_ovf, o_cout, o_sum} !== e.res) begin
            n_bad++; $display("FAIL rst_post_result: got %h expected %h", {o_ovf, o_cout, o_sum}, e.res);
          end
          n_cmp++; if (step_no - e.t != 4) begin n_bad++; $display("FAIL rst_post_latency: got %0d expected 4", step_no - e.t); end
        end
      end
      if (n < 5 && o_ready) q.push_back('{golden(16, a, b, sub, cin), step_no});
    end
    n_cmp++; if (got != 5) begin n_bad++; $display("FAIL rst_post_count: got %0d expected 5", got); end
  endtask

  task automatic test_w4_exhaustive();
    exp_t q[$];
    exp_t e;
    int got = 0;
    logic [9:0] idx;
    bit iv;
    for (int n = 0; n < 1028; n++) begin
      iv = (n < 1024); idx = 10'(n);
      step4(iv, idx[3:0], idx[7:4], idx[8], idx[9]);
      if (o_valid) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL w4_spurious: got out_valid=1 expected 0");
        end else begin
          e = q.pop_front(); got++;
          if ({o_ovf, o_cout, o_sum} !== e.res) begin
            n_bad++; $display("FAIL w4_result: got %h expected %h", {o_ovf, o_cout, o_sum}, e.res);
          end
          n_cmp++; if (step_no - e.t != 1) begin n_bad++; $display("FAIL w4_latency: got %0d expected 1", step_no - e.t); end
        end
      end
      if (iv && o_ready) q.push_back('{golden(4, idx[3:0], idx[7:4], idx[8], idx[9]), step_no});
    end
    n_cmp++; if (got != 1024) begin n_bad++; $display("FAIL w4_count: got %0d expected 1024", got); end
  endtask

  initial begin
    reset = 1'b1;
    iv16 = 0; or16 = 1; a16 = '0; b16 = '0; sub16 = 0; cin16 = 0;
    iv4 = 0; or4 = 1; a4 = '0; b4 = '0; sub4 = 0; cin4 = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_w4_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
